// File: rtl/vend_txn_ctrl.sv
// ----------------------------------------------------------------------------
// vend_txn_ctrl : coin credit, item selection, dispense and change sequencing
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vend_txn_ctrl #(
  parameter int PRICE_GRAPE     = 5,
  parameter int PRICE_ORANGE    = 10,
  parameter int PRICE_MANGO     = 15,
  parameter int PRICE_PINEAPPLE = 20,
  parameter int MAX_CREDIT      = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_valid,
  input  logic [4:0] coin_val,
  input  logic       sel_valid,
  input  logic [2:0] item_sel,
  input  logic       cancel,
  input  logic       vend_ack,
  input  logic       chg_ack,
  output logic       coin_accept,
  output logic       coin_reject,
  output logic       sel_err,
  output logic       vend_req,
  output logic [2:0] vend_item,
  output logic       vend_done,
  output logic       chg_req,
  output logic [4:0] chg_coin,
  output logic [5:0] credit,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [5:0] credit_nxt;
  logic [2:0] vend_item_nxt;
  logic       vend_req_nxt, chg_req_nxt;
  logic [4:0] chg_coin_nxt;
  logic       accept_nxt, reject_nxt, err_nxt, done_nxt;

  logic [6:0] coin_sum;
  logic       coin_val_ok, coin_ok;
  logic       code_ok;
  logic [5:0] price;
  logic [5:0] change_left;

  function automatic logic [4:0] greedy_coin(input logic [5:0] amt);
    if (amt >= 6'd20)      greedy_coin = 5'd20;
    else if (amt >= 6'd10) greedy_coin = 5'd10;
    else if (amt >= 6'd5)  greedy_coin = 5'd5;
    else                   greedy_coin = 5'd0;
  endfunction

  function automatic logic [5:0] price_of(input logic [2:0] code);
    case (code)
      3'd1:    price_of = 6'(PRICE_GRAPE);
      3'd2:    price_of = 6'(PRICE_ORANGE);
      3'd3:    price_of = 6'(PRICE_MANGO);
      3'd4:    price_of = 6'(PRICE_PINEAPPLE);
      default: price_of = 6'd0;
    endcase
  endfunction

  // Sum is one bit wider than credit so the ceiling test cannot wrap.
  assign coin_sum    = {1'b0, credit} + {2'b00, coin_val};
  assign coin_val_ok = (coin_val == 5'd5) || (coin_val == 5'd10) || (coin_val == 5'd20);
  assign coin_ok     = coin_val_ok && (coin_sum <= 7'(MAX_CREDIT));
  assign code_ok     = (item_sel >= 3'd1) && (item_sel <= 3'd4);
  assign price       = price_of(item_sel);
  assign change_left = credit - {1'b0, chg_coin};

  always_comb begin
    state_nxt     = state;
    credit_nxt    = credit;
    vend_item_nxt = vend_item;
    vend_req_nxt  = vend_req;
    chg_req_nxt   = chg_req;
    chg_coin_nxt  = chg_coin;
    accept_nxt    = 1'b0;
    reject_nxt    = 1'b0;
    err_nxt       = 1'b0;
    done_nxt      = 1'b0;

    case (state)
      IDLE, COLLECT: begin
        // cancel outranks coin, coin outranks selection; losers are dropped.
        if (cancel) begin
          if ((state == COLLECT) && (credit != 6'd0)) begin
            state_nxt    = CHANGE;
            chg_req_nxt  = 1'b1;
            chg_coin_nxt = greedy_coin(credit);
          end
        end else if (coin_valid) begin
          if (coin_ok) begin
            credit_nxt = coin_sum[5:0];
            accept_nxt = 1'b1;
            state_nxt  = COLLECT;
          end else begin
            reject_nxt = 1'b1;
          end
        end else if (sel_valid) begin
          if (!code_ok || (credit < price)) begin
            err_nxt = 1'b1;
          end else begin
            credit_nxt    = credit - price;
            vend_item_nxt = item_sel;
            vend_req_nxt  = 1'b1;
            state_nxt     = DISPENSE;
          end
        end
      end

      DISPENSE: begin
        reject_nxt = coin_valid;
        if (vend_ack) begin
          vend_req_nxt = 1'b0;
          done_nxt     = 1'b1;
          if (credit != 6'd0) begin
            state_nxt    = CHANGE;
            chg_req_nxt  = 1'b1;
            chg_coin_nxt = greedy_coin(credit);
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      CHANGE: begin
        reject_nxt = coin_valid;
        if (chg_ack) begin
          credit_nxt = change_left;
          if (change_left == 6'd0) begin
            state_nxt    = IDLE;
            chg_req_nxt  = 1'b0;
            chg_coin_nxt = 5'd0;
          end else begin
            chg_coin_nxt = greedy_coin(change_left);
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      credit      <= 6'd0;
      vend_item   <= 3'd0;
      vend_req    <= 1'b0;
      chg_req     <= 1'b0;
      chg_coin    <= 5'd0;
      coin_accept <= 1'b0;
      coin_reject <= 1'b0;
      sel_err     <= 1'b0;
      vend_done   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      vend_item   <= vend_item_nxt;
      vend_req    <= vend_req_nxt;
      chg_req     <= chg_req_nxt;
      chg_coin    <= chg_coin_nxt;
      coin_accept <= accept_nxt;
      coin_reject <= reject_nxt;
      sel_err     <= err_nxt;
      vend_done   <= done_nxt;
      busy        <= (state_nxt == DISPENSE) || (state_nxt == CHANGE);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vend_txn_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vend_txn_ctrl : directed vector table plus async-reset sequences
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_vend_txn_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coin_valid, sel_valid, cancel, vend_ack, chg_ack;
  logic [4:0] coin_val;
  logic [2:0] item_sel;
  logic       coin_accept, coin_reject, sel_err, vend_req, vend_done, chg_req, busy;
  logic [2:0] vend_item;
  logic [4:0] chg_coin;
  logic [5:0] credit;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       cv;
    logic [4:0] cval;
    logic       sv;
    logic [2:0] isel;
    logic       can;
    logic       vack;
    logic       cack;
    logic [20:0] exp;
  } vec_t;

  vec_t vecs[$];

  vend_txn_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .coin_valid  (coin_valid),
    .coin_val    (coin_val),
    .sel_valid   (sel_valid),
    .item_sel    (item_sel),
    .cancel      (cancel),
    .vend_ack    (vend_ack),
    .chg_ack     (chg_ack),
    .coin_accept (coin_accept),
    .coin_reject (coin_reject),
    .sel_err     (sel_err),
    .vend_req    (vend_req),
    .vend_item   (vend_item),
    .vend_done   (vend_done),
    .chg_req     (chg_req),
    .chg_coin    (chg_coin),
    .credit      (credit),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  logic [20:0] outs;
  assign outs = {coin_accept, coin_reject, sel_err, vend_req, vend_item,
                 vend_done, chg_req, chg_coin, credit, busy};

  // Output order: acc rej err vreq vitem vdone creq ccoin credit busy
  task automatic add(input logic cv, input logic [4:0] cval, input logic sv,
                     input logic [2:0] isel, input logic can, input logic vack,
                     input logic cack, input logic acc, input logic rej,
                     input logic err, input logic vreq, input logic [2:0] vitem,
                     input logic vdone, input logic creq, input logic [4:0] ccoin,
                     input logic [5:0] cr, input logic bsy);
    vec_t v;
    v.cv = cv; v.cval = cval; v.sv = sv; v.isel = isel;
    v.can = can; v.vack = vack; v.cack = cack;
    v.exp = {acc, rej, err, vreq, vitem, vdone, creq, ccoin, cr, bsy};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [20:0] exp);
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL %s: got acc=%b rej=%b err=%b vreq=%b vitem=%0d vdone=%b creq=%b ccoin=%0d credit=%0d busy=%b, expected acc=%b rej=%b err=%b vreq=%b vitem=%0d vdone=%b creq=%b ccoin=%0d credit=%0d busy=%b",
               name, outs[20], outs[19], outs[18], outs[17], outs[16:14], outs[13],
               outs[12], outs[11:7], outs[6:1], outs[0],
               exp[20], exp[19], exp[18], exp[17], exp[16:14], exp[13],
               exp[12], exp[11:7], exp[6:1], exp[0]);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    coin_valid = v.cv; coin_val = v.cval; sel_valid = v.sv; item_sel = v.isel;
    cancel = v.can; vend_ack = v.vack; chg_ack = v.cack;
    @(posedge clk);
    #1;
    chk(name, v.exp);
  endtask

  task automatic clear_inputs();
    coin_valid = 1'b0; coin_val = 5'd0; sel_valid = 1'b0; item_sel = 3'd0;
    cancel = 1'b0; vend_ack = 1'b0; chg_ack = 1'b0;
  endtask

  task automatic step(input logic cv, input logic [4:0] cval, input logic sv,
                      input logic [2:0] isel, input logic vack,
                      input logic [20:0] exp, input string name);
    vec_t v;
    v.cv = cv; v.cval = cval; v.sv = sv; v.isel = isel;
    v.can = 1'b0; v.vack = vack; v.cack = 1'b0; v.exp = exp;
    apply(v, name);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();

    // Plan 1: coins 10,5 then Mango, no change
    add(1,10,0,0,0,0,0, 1,0,0,0,0,0,0, 0,10,0);
    add(1, 5,0,0,0,0,0, 1,0,0,0,0,0,0, 0,15,0);
    add(0, 0,1,3,0,0,0, 0,0,0,1,3,0,0, 0, 0,1);
    add(0, 0,0,0,0,0,0, 0,0,0,1,3,0,0, 0, 0,1);
    add(0, 0,0,0,0,1,0, 0,0,0,0,3,1,0, 0, 0,0);
    add(0, 0,0,0,0,0,0, 0,0,0,0,3,0,0, 0, 0,0);
    // Plan 2: 40 credit, Grape, change 20/10/5
    add(1,20,0,0,0,0,0, 1,0,0,0,3,0,0, 0,20,0);
    add(1,20,0,0,0,0,0, 1,0,0,0,3,0,0, 0,40,0);
    add(0, 0,1,1,0,0,0, 0,0,0,1,1,0,0, 0,35,1);
    add(0, 0,0,0,0,1,0, 0,0,0,0,1,1,1,20,35,1);
    add(0, 0,0,0,0,0,0, 0,0,0,0,1,0,1,20,35,1);
    add(0, 0,0,0,0,0,1, 0,0,0,0,1,0,1,10,15,1);
    add(0, 0,0,0,0,0,1, 0,0,0,0,1,0,1, 5, 5,1);
    add(0, 0,0,0,0,0,1, 0,0,0,0,1,0,0, 0, 0,0);
    // Plan 3: ceiling, illegal coin, stray ack, select with no credit
    add(1,20,0,0,0,0,0, 1,0,0,0,1,0,0, 0,20,0);
    add(1,20,0,0,0,0,0, 1,0,0,0,1,0,0, 0,40,0);
    add(1, 5,0,0,0,0,0, 0,1,0,0,1,0,0, 0,40,0);
    add(0, 0,0,0,1,0,0, 0,0,0,0,1,0,1,20,40,1);
    add(0, 0,0,0,0,0,1, 0,0,0,0,1,0,1,20,20,1);
    add(0, 0,0,0,0,0,1, 0,0,0,0,1,0,0, 0, 0,0);
    add(1, 7,0,0,0,0,0, 0,1,0,0,1,0,0, 0, 0,0);
    add(0, 0,0,0,0,1,0, 0,0,0,0,1,0,0, 0, 0,0);
    add(0, 0,1,1,0,0,0, 0,0,1,0,1,0,0, 0, 0,0);
    // Plan 4: bad codes, short credit, cancel refund
    add(1,10,0,0,0,0,0, 1,0,0,0,1,0,0, 0,10,0);
    add(0, 0,1,4,0,0,0, 0,0,1,0,1,0,0, 0,10,0);
    add(0, 0,1,0,0,0,0, 0,0,1,0,1,0,0, 0,10,0);
    add(0, 0,1,5,0,0,0, 0,0,1,0,1,0,0, 0,10,0);
    add(0, 0,1,3,0,0,0, 0,0,1,0,1,0,0, 0,10,0);
    add(0, 0,0,0,1,0,0, 0,0,0,0,1,0,1,10,10,1);
    add(0, 0,0,0,0,0,1, 0,0,0,0,1,0,0, 0, 0,0);
    // Plan 5: priority, coins while busy, sel/cancel ignored in DISPENSE
    add(1, 5,0,0,0,0,0, 1,0,0,0,1,0,0, 0, 5,0);
    add(1, 5,1,1,1,0,0, 0,0,0,0,1,0,1, 5, 5,1);
    add(1,10,0,0,0,0,0, 0,1,0,0,1,0,1, 5, 5,1);
    add(0, 0,0,0,0,0,1, 0,0,0,0,1,0,0, 0, 0,0);
    add(1,10,0,0,0,0,0, 1,0,0,0,1,0,0, 0,10,0);
    add(0, 0,1,2,0,0,0, 0,0,0,1,2,0,0, 0, 0,1);
    add(1, 5,0,0,0,0,0, 0,1,0,1,2,0,0, 0, 0,1);
    add(0, 0,1,1,1,0,0, 0,0,0,1,2,0,0, 0, 0,1);
    add(0, 0,0,0,0,1,0, 0,0,0,0,2,1,0, 0, 0,0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 21'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Plan 6a: async reset while vend_req is high
    step(1, 5'd10, 0, 3'd0, 0, {1'b1,1'b0,1'b0,1'b0,3'd2,1'b0,1'b0,5'd0,6'd10,1'b0}, "p6_coin10");
    step(0, 5'd0,  1, 3'd2, 0, {1'b0,1'b0,1'b0,1'b1,3'd2,1'b0,1'b0,5'd0,6'd0,1'b1},  "p6_sel2");
    #2 rst_n = 1'b0;
    #1 chk("async_rst_vend", 21'd0);
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Plan 6b: async reset while chg_req is high
    step(1, 5'd20, 0, 3'd0, 0, {1'b1,1'b0,1'b0,1'b0,3'd0,1'b0,1'b0,5'd0,6'd20,1'b0}, "p6_coin20");
    step(0, 5'd0,  1, 3'd1, 0, {1'b0,1'b0,1'b0,1'b1,3'd1,1'b0,1'b0,5'd0,6'd15,1'b1}, "p6_sel1");
    step(0, 5'd0,  0, 3'd0, 1, {1'b0,1'b0,1'b0,1'b0,3'd1,1'b1,1'b1,5'd10,6'd15,1'b1}, "p6_vack");
    #2 rst_n = 1'b0;
    #1 chk("async_rst_chg", 21'd0);
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    step(1, 5'd5, 0, 3'd0, 0, {1'b1,1'b0,1'b0,1'b0,3'd0,1'b0,1'b0,5'd0,6'd5,1'b0}, "p6_after_rst");
    @(negedge clk);
    clear_inputs();
    @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
